// File: rtl/regfile_write_arbiter_if.sv
// Bundle of every non-clock/reset signal of regfile_write_arbiter.
//   slave  : the arbiter side (takes requests and read addresses, drives
//            readies, the register-file write port, forwarding and counter)
//   master : the requester / register-file / reader side
// Signals:
//   a_valid/a_ready/a_addr/a_data : requester A (ALU/execute) writeback
//   b_valid/b_ready/b_addr/b_data : requester B (load/store return) writeback
//   rf_write/rf_inAddress/rf_in   : registered register-file write port
//   rd_addr1/rd_addr2             : read addresses for forwarding compare
//   fwd_hit1/fwd_hit2/fwd_data    : forwarding results
//   x0_drops                      : saturating count of absorbed x0 writes
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_inAddress;
  logic [DATA_W-1:0] rf_in;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  x0_drops;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  rd_addr1, rd_addr2,
    output a_ready, b_ready,
    output rf_write, rf_inAddress, rf_in,
    output fwd_hit1, fwd_hit2, fwd_data,
    output x0_drops
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output rd_addr1, rd_addr2,
    input  a_ready, b_ready,
    input  rf_write, rf_inAddress, rf_in,
    input  fwd_hit1, fwd_hit2, fwd_data,
    input  x0_drops
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// two writeback requesters (A: execute, B: load/store return).
// Ports:
//   clk : system clock, all state on rising edge
//   rst : synchronous active-low reset
//   bus : regfile_write_arbiter_if.slave (handshakes, write port,
//         forwarding compares, x0 drop counter)
// One handshake is accepted per cycle; the accepted write appears on the
// register-file port in the following cycle. Writes to x0 are accepted but
// absorbed and counted.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } grant_e;

  grant_e            last_grant;
  grant_e            last_grant_nxt;

  logic              a_rdy;
  logic              b_rdy;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_is_x0;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  drops_q;

  // Grant selection: a lone requester wins; on a tie the requester that
  // did not win last time wins. Nothing is granted while in reset.
  always_comb begin
    a_rdy          = 1'b0;
    b_rdy          = 1'b0;
    last_grant_nxt = last_grant;
    if (rst) begin
      if (bus.a_valid && (!bus.b_valid || last_grant == LAST_B)) begin
        a_rdy = 1'b1;
      end else if (bus.b_valid) begin
        b_rdy = 1'b1;
      end
    end
    if (a_rdy) begin
      last_grant_nxt = LAST_A;
    end else if (b_rdy) begin
      last_grant_nxt = LAST_B;
    end
  end

  always_comb begin
    accept    = a_rdy || b_rdy;
    sel_addr  = b_rdy ? bus.b_addr : bus.a_addr;
    sel_data  = b_rdy ? bus.b_data : bus.a_data;
    sel_is_x0 = (sel_addr == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= LAST_B;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      drops_q    <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      wr_q       <= accept && !sel_is_x0;
      // x0 writes leave the port address/data untouched.
      if (accept && !sel_is_x0) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      if (accept && sel_is_x0 && (drops_q != '1)) begin
        drops_q <= drops_q + CNT_W'(1);
      end
    end
  end

  assign bus.a_ready      = a_rdy;
  assign bus.b_ready      = b_rdy;
  assign bus.rf_write     = wr_q;
  assign bus.rf_inAddress = addr_q;
  assign bus.rf_in        = data_q;
  assign bus.x0_drops     = drops_q;
  assign bus.fwd_data     = data_q;
  assign bus.fwd_hit1     = wr_q && (bus.rd_addr1 == addr_q) && (bus.rd_addr1 != '0);
  assign bus.fwd_hit2     = wr_q && (bus.rd_addr2 == addr_q) && (bus.rd_addr2 != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.rd_addr1 = '0;  bus.rd_addr2 = '0;

    // 1. Reset with A requesting
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h55;
    tick(); tick();
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_rf_write", bus.rf_write, 0);
    chk("rst_addr", bus.rf_inAddress, 0);
    chk("rst_data", bus.rf_in, 0);
    chk("rst_drops", bus.x0_drops, 0);
    rst = 1'b1;
    #1;
    chk("rel_a_ready", bus.a_ready, 1);
    tick();
    chk("rel_wr", bus.rf_write, 1);
    chk("rel_addr", bus.rf_inAddress, 5);
    chk("rel_data", bus.rf_in, 32'h55);

    // 2. Single write
    bus.a_addr = 5'd3; bus.a_data = 32'hDEADBEEF;
    #1;
    chk("single_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    chk("single_wr", bus.rf_write, 1);
    chk("single_addr", bus.rf_inAddress, 3);
    chk("single_data", bus.rf_in, 32'hDEADBEEF);
    tick();
    chk("single_idle", bus.rf_write, 0);

    // 3. Contention after reset: A first, then alternate
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a_ready", bus.a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_b_ready", bus.b_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_wr", bus.rf_write, 1);
      chk("rr_addr", bus.rf_inAddress, (i % 2 == 0) ? 1 : 2);
      chk("rr_data", bus.rf_in, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    chk("rr_idle", bus.rf_write, 0);

    // 4. x0 writes absorbed and counted, saturating at 255
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'hFFFF;
    #1;
    chk("x0_ready", bus.b_ready, 1);
    tick();
    chk("x0_wr", bus.rf_write, 0);
    chk("x0_drops1", bus.x0_drops, 1);
    chk("x0_hold_addr", bus.rf_inAddress, 2);
    chk("x0_hold_data", bus.rf_in, 32'h22);
    for (int i = 1; i < 255; i++) tick();
    chk("x0_drops255", bus.x0_drops, 255);
    for (int i = 255; i < 300; i++) tick();
    chk("x0_sat", bus.x0_drops, 255);
    chk("x0_sat_wr", bus.rf_write, 0);
    bus.b_valid = 1'b0;

    // 5. Forwarding
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h1234;
    tick();
    bus.a_valid = 1'b0;
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd0;
    #1;
    chk("fwd_hit1", bus.fwd_hit1, 1);
    chk("fwd_data", bus.fwd_data, 32'h1234);
    chk("fwd_hit2_x0", bus.fwd_hit2, 0);
    bus.rd_addr2 = 5'd7; bus.rd_addr1 = 5'd6;
    #1;
    chk("fwd_hit2", bus.fwd_hit2, 1);
    chk("fwd_miss1", bus.fwd_hit1, 0);
    tick();
    chk("fwd_idle", bus.fwd_hit2, 0);
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;

    // 6. Reset mid-operation
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h44;
    tick();
    bus.a_valid = 1'b0;
    rst = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h99;
    #1;
    chk("mid_wr", bus.rf_write, 1);
    chk("mid_addr", bus.rf_inAddress, 4);
    chk("mid_b_ready_rst", bus.b_ready, 0);
    tick();
    chk("mid_wr_clr", bus.rf_write, 0);
    chk("mid_addr_clr", bus.rf_inAddress, 0);
    chk("mid_drops_clr", bus.x0_drops, 0);
    chk("mid_b_ready_rst2", bus.b_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_b_ready_rel", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    chk("mid_b_wr", bus.rf_write, 1);
    chk("mid_b_addr", bus.rf_inAddress, 9);
    chk("mid_b_data", bus.rf_in, 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (load/store unit return).
- Uses valid/ready handshakes with round-robin arbitration, one accepted write per cycle.
- Registers the granted write onto the register file's write port (write, inAddress, in).
- Silently absorbs writes to x0 and counts them.
- Provides same-cycle forwarding compares for the two read ports, so readers can bypass a write that is in flight.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- CNT_W, 8, width of the saturating x0-drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; sampled on rising edge of clk; state cleared when rst==0.
- a_valid  input  1  requester A has a write.
- a_ready  output  1  A's write is accepted this cycle.
- a_addr  input  ADDR_W  A's destination register.
- a_data  input  DATA_W  A's write data.
- b_valid  input  1  requester B has a write.
- b_ready  output  1  B's write is accepted this cycle.
- b_addr  input  ADDR_W  B's destination register.
- b_data  input  DATA_W  B's write data.
- rf_write  output  1  register file write enable.
- rf_inAddress  output  ADDR_W  register file write address.
- rf_in  output  DATA_W  register file write data.
- rd_addr1  input  ADDR_W  register file read address 1, for forwarding compare.
- rd_addr2  input  ADDR_W  register file read address 2, for forwarding compare.
- fwd_hit1  output  1  rd_addr1 matches the write currently on the port.
- fwd_hit2  output  1  rd_addr2 matches the write currently on the port.
- fwd_data  output  DATA_W  data to forward; equals rf_in.
- x0_drops  output  CNT_W  saturating count of accepted writes to x0.

Behaviour:
- Reset (rst==0 at an edge):
  - rf_write=0, rf_inAddress=0, rf_in=0, x0_drops=0.
  - Round-robin pointer last_grant=B, so A wins the first tie.
  - a_ready=b_ready=0 combinationally while rst==0; no handshake completes in a reset cycle.
- Handshake:
  - A write is accepted at a rising edge where valid&&ready are both high.
  - a_ready/b_ready are combinational from the valids and last_grant; at most one is high in a cycle.
  - A requester must hold valid, addr and data stable until ready. The block does not check this.
- Arbitration:
  - Only one valid: that requester gets ready.
  - Both valid: the requester not equal to last_grant gets ready.
  - last_grant updates only on an accepted handshake.
  - Both held valid continuously: grants alternate A,B,A,B; no starvation beyond 1 cycle.
- Write stage latency:
  - Acceptance at edge k with addr!=0 gives rf_write=1 with that addr/data for exactly the cycle after edge k.
  - If there is no acceptance at edge k, rf_write=0 in that cycle.
  - Sustained throughput is 1 write/cycle.
- x0 writes:
  - Accepted normally (ready asserted) but rf_write stays 0.
  - rf_inAddress/rf_in hold their previous values.
  - x0_drops increments by 1 and saturates at 2^CNT_W-1.
- Forwarding (combinational):
  - fwd_hitN = rf_write && (rd_addrN==rf_inAddress) && (rd_addrN!=0).
  - fwd_data=rf_in.
  - Both hits may be high together.
- Reset mid-operation:
  - A write accepted at edge k is already on the port in cycle k+1 and is not retracted.
  - If rst==0 at edge k+1, outputs clear at that edge.
  - A valid request pending during reset is not accepted and must be re-presented; requesters keep valid asserted.
- The block performs no arithmetic except the counter.

Test Plan:
1. Reset: rst=0 for 2 cycles with a_valid=1, a_addr=5 -> a_ready=0, rf_write=0, x0_drops=0. Release rst -> a_ready=1 on the first cycle with rst==1.
2. Single write: a_valid=1, a_addr=3, a_data=0xDEADBEEF for one cycle -> a_ready=1 that cycle. Next cycle rf_write=1, rf_inAddress=3, rf_in=0xDEADBEEF. The cycle after, rf_write=0.
3. Contention: A (addr 1, 0x11) and B (addr 2, 0x22) both held valid for 4 cycles after reset -> ready sequence A,B,A,B. rf writes addr 1,2,1,2 one cycle later each.
4. x0: b_valid=1, b_addr=0, b_data=0xFFFF for 1 cycle -> b_ready=1, rf_write stays 0, x0_drops=1. Hold for 300 accepts -> x0_drops=255.
5. Forwarding: accept A addr 7, data 0x1234. In the write cycle set rd_addr1=7, rd_addr2=0 -> fwd_hit1=1, fwd_data=0x1234, fwd_hit2=0. Set rd_addr2=7 -> fwd_hit2=1.
6. Reset mid-op: accept A addr 4 at edge k, drive rst=0 at edge k+1 with b_valid=1 -> rf_write=1 in cycle k+1, then 0. b_ready=0 during reset. B is accepted on the first cycle after release.
